sdm_interp_feeder: RTL and testbench

Upstream feeder for the 2nd-order sigma-delta DAC modulator. Accepts unsigned samples at a low rate over a valid/ready handshake and linearly interpolates between consecutive samples by a factor of 2^LOG2_INTERP. Drives the modulator's data input and its clock-enable strobe. Also flags underrun when the source fails to deliver a sample in time.

---
 rtl/sdm_pkg.sv | 19 +
 rtl/sdm_ce_div.sv | 58 +++++
 rtl/sdm_interp_feeder.sv | 140 ++++++++++++++
 tb/tb_sdm_interp_feeder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdm_pkg
// Purpose  : Default sizing constants shared by the sigma-delta DAC chain.
//            The modulator top level and the interpolating feeder both
//            import these, so they agree on the sample width and timebase.
// Contents : c_sdm_width       - sample / modulator data width (unsigned)
//            c_sdm_log2_interp - log2 of the interpolation factor
//            c_sdm_ce_div      - system clocks per modulator enable strobe
// Revision : 1.0 - initial release
// ============================================================================
package sdm_pkg;

  localparam int c_sdm_width       = 8;
  localparam int c_sdm_log2_interp = 4;
  localparam int c_sdm_ce_div      = 4;

endpackage : sdm_pkg
`default_nettype wire

// File: rtl/sdm_ce_div.sv
`default_nettype none
// ============================================================================
// Module   : sdm_ce_div
// Purpose  : Prescaler producing the modulator clock-enable timebase.
//            Counts 0..CE_DIV-1 while enabled; o_tick is high (combinational)
//            in the last count, o_sd_en is the registered copy of o_tick, so
//            it is a one-cycle strobe in the cycle after each tick.
//            CE_DIV must be at least 2.
// Ports    : i_clk    - system clock
//            i_rst_n  - asynchronous active-low reset
//            i_en     - run enable; low holds the count and suppresses ticks
//            o_tick   - internal tick, valid in the cycle the count wraps
//            o_sd_en  - registered one-cycle enable strobe
// Revision : 1.0 - initial release
// ============================================================================
module sdm_ce_div
  import sdm_pkg::*;
#(
  parameter int CE_DIV = c_sdm_ce_div
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick,
  output logic o_sd_en
);

  localparam int                  c_cnt_w = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(CE_DIV - 1);

  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               sd_en_q, sd_en_d;
  logic               w_tick;

  always_comb begin
    w_tick  = i_en && (cnt_q == c_last);
    cnt_d   = cnt_q;
    if (i_en) begin
      cnt_d = w_tick ? '0 : cnt_q + c_cnt_w'(1);
    end
    sd_en_d = w_tick;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      sd_en_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sd_en_q <= sd_en_d;
    end
  end

  assign o_tick  = w_tick;
  assign o_sd_en = sd_en_q;

endmodule : sdm_ce_div
`default_nettype wire

// File: rtl/sdm_interp_feeder.sv
`default_nettype none
// ============================================================================
// Module   : sdm_interp_feeder
// Purpose  : Upstream feeder for the 2nd-order sigma-delta DAC modulator.
//            Accepts unsigned samples over valid/ready into a one-deep
//            buffer and linearly interpolates between consecutive samples by
//            2**LOG2_INTERP, one step per modulator enable strobe. Flags a
//            sticky underrun when a segment ends with no new sample.
// Ports    : i_clk, i_rst_n   - clock, asynchronous active-low reset
//            i_en             - run enable; low freezes the timebase
//            i_data, i_valid  - input sample handshake (unsigned)
//            o_ready          - buffer empty, sample accepted this cycle
//            o_data           - interpolated value for the modulator
//            o_sd_en          - one-cycle modulator enable strobe
//            o_underrun       - sticky underrun flag
//            i_clr_underrun   - synchronous clear of o_underrun
// Revision : 1.0 - initial release
// ============================================================================
module sdm_interp_feeder
  import sdm_pkg::*;
#(
  parameter int WIDTH       = c_sdm_width,
  parameter int LOG2_INTERP = c_sdm_log2_interp,
  parameter int CE_DIV      = c_sdm_ce_div
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sd_en,
  output logic             o_underrun,
  input  logic             i_clr_underrun
);

  localparam int                      c_pw         = WIDTH + LOG2_INTERP + 1;
  localparam logic [LOG2_INTERP-1:0]  c_phase_last = '1;

  logic [LOG2_INTERP-1:0] phase_q, phase_d;
  logic [WIDTH-1:0]       prev_q, prev_d;
  logic [WIDTH-1:0]       cur_q, cur_d;
  logic [WIDTH-1:0]       nxt_q, nxt_d;
  logic                   nxt_vld_q, nxt_vld_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   underrun_q, underrun_d;

  logic                   w_tick;
  logic                   w_wrap;
  logic                   w_underrun_set;
  logic signed [WIDTH:0]  w_diff;
  logic signed [c_pw-1:0] w_prod;
  logic [WIDTH-1:0]       w_interp;
  logic                   w_unused_prod;

  sdm_ce_div #(
    .CE_DIV (CE_DIV)
  ) u_ce_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .o_tick  (w_tick),
    .o_sd_en (o_sd_en)
  );

  // prev + floor(diff * p / L). The sum always lies between prev and cur, so
  // keeping only the low WIDTH bits of the shifted product and adding modulo
  // 2**WIDTH gives the exact result. The bits dropped by the shift are the
  // floor, and the product sign bit is implied by the in-range result.
  always_comb begin
    w_diff   = $signed({1'b0, cur_q}) - $signed({1'b0, prev_q});
    w_prod   = $signed({{LOG2_INTERP{w_diff[WIDTH]}}, w_diff})
             * $signed({{(WIDTH + 1){1'b0}}, phase_q});
    w_interp = prev_q + w_prod[WIDTH+LOG2_INTERP-1:LOG2_INTERP];
    w_unused_prod = &{1'b0, w_prod[c_pw-1], w_prod[LOG2_INTERP-1:0]};
  end

  assign w_wrap  = w_tick && (phase_q == c_phase_last);
  assign o_ready = ~nxt_vld_q;

  always_comb begin
    phase_d        = phase_q;
    prev_d         = prev_q;
    cur_d          = cur_q;
    nxt_d          = nxt_q;
    nxt_vld_d      = nxt_vld_q;
    data_d         = data_q;
    w_underrun_set = 1'b0;

    if (w_tick) begin
      data_d  = w_interp;
      phase_d = phase_q + LOG2_INTERP'(1);
    end

    if (w_wrap) begin
      prev_d = cur_q;
      if (nxt_vld_q) begin
        cur_d     = nxt_q;
        nxt_vld_d = 1'b0;
      end else if (i_valid) begin
        // Sample arriving exactly on the wrap goes straight to cur.
        cur_d = i_data;
      end else begin
        w_underrun_set = 1'b1;
      end
    end else if (i_valid && !nxt_vld_q) begin
      nxt_d     = i_data;
      nxt_vld_d = 1'b1;
    end

    // A set in the same cycle as a clear keeps the flag high.
    underrun_d = w_underrun_set | (underrun_q & ~i_clr_underrun);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_q    <= '0;
      prev_q     <= '0;
      cur_q      <= '0;
      nxt_q      <= '0;
      nxt_vld_q  <= 1'b0;
      data_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      prev_q     <= prev_d;
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      nxt_vld_q  <= nxt_vld_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
    end
  end

  assign o_data     = data_q;
  assign o_underrun = underrun_q;

endmodule : sdm_interp_feeder
`default_nettype wire

// File: tb/tb_sdm_interp_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdm_interp_feeder
// Purpose  : Self-checking bench for sdm_interp_feeder (WIDTH=8, L=16,
//            CE_DIV=4). Every o_sd_en strobe pops the expected o_data from a
//            scoreboard queue filled from a reference interpolation model;
//            a small table adds hand-computed spot values, and hand-written
//            sequences cover reset, underrun, backpressure, bypass and freeze.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdm_interp_feeder;

  localparam int L = 16;

  logic       clk = 1'b0;
  logic       rst_n, en, valid, clr;
  logic [7:0] din;
  logic       ready, sd_en, underrun;
  logic [7:0] dout;

  sdm_interp_feeder #(
    .WIDTH       (8),
    .LOG2_INTERP (4),
    .CE_DIV      (4)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_en           (en),
    .i_data         (din),
    .i_valid        (valid),
    .o_ready        (ready),
    .o_data         (dout),
    .o_sd_en        (sd_en),
    .o_underrun     (underrun),
    .i_clr_underrun (clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] smp;
    logic [7:0] e1;
    logic [7:0] e15;
  } vec_t;

  vec_t       tab[5];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] src_q[$];
  int         pulse_cnt = 0;
  int         cyc_cnt = 0;
  int         last_pulse_cyc = 0;
  bit         feed_on = 1'b0;
  bit         feed_acc = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Weighted-average form: (prev*(L-p) + cur*p) / L, numerator never negative.
  function automatic logic [7:0] ref_val(input int prev, input int cur, input int p);
    int num;
    num = prev * (L - p) + cur * p;
    return 8'(num / L);
  endfunction

  task automatic push_seg(input int prev, input int cur, input int n);
    for (int p = 0; p < n; p++) exp_q.push_back(ref_val(prev, cur, p));
  endtask

  // One clock: observe at the falling edge, then drive the source.
  task automatic cycle();
    logic [7:0] e;
    @(negedge clk);
    cyc_cnt++;
    if (sd_en) begin
      pulse_cnt++;
      last_pulse_cyc = cyc_cnt;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_pulse %0d: got data 0x%0h expected no strobe", pulse_cnt, dout);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("sb_data_pulse%0d", pulse_cnt), dout, e);
      end
    end
    if (feed_on) begin
      if (feed_acc) begin
        void'(src_q.pop_front());
        valid = 1'b0;
      end
      if (!valid && src_q.size() > 0) begin
        valid = 1'b1;
        din   = src_q[0];
      end
      feed_acc = valid && ready;
    end
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (pulse_cnt < target) begin
      cycle();
      guard++;
      if (guard > 2000) begin
        checks++;
        errors++;
        $display("FAIL timeout waiting for pulse %0d: got %0d pulses", target, pulse_cnt);
        return;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, dout, 0);
    check({tag, "_sd_en"}, sd_en, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_ready"}, ready, 1);
  endtask

  initial begin
    int prev_pc, c0, p0, changes, guard;
    logic [7:0] hold_val;

    tab[0] = '{8'hFF, 8'h0F, 8'hEF};
    tab[1] = '{8'h00, 8'hEF, 8'h0F};
    tab[2] = '{8'h05, 8'h00, 8'h04};
    tab[3] = '{8'h02, 8'h04, 8'h02};
    tab[4] = '{8'h80, 8'h09, 8'h78};

    rst_n = 1'b0; en = 1'b0; valid = 1'b0; clr = 1'b0; din = 8'h00;
    #2;
    check_reset_outputs("rst_init");
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    // Ramp up, ramp down, then the table of sample pairs.
    src_q = '{8'h10, 8'h10, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h05, 8'h02, 8'h80, 8'h77, 8'h99};
    push_seg(8'h00, 8'h00, L);
    push_seg(8'h00, 8'h10, L);
    push_seg(8'h10, 8'h10, L);
    push_seg(8'h10, 8'h00, L);
    push_seg(8'h00, 8'h00, L);
    for (int i = 0; i < 5; i++) push_seg((i == 0) ? 0 : int'(tab[i-1].smp), int'(tab[i].smp), L);
    push_seg(8'h80, 8'h77, L);
    feed_on = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_to((5 + i) * L + 2);
      check($sformatf("tab%0d_p1", i), dout, tab[i].e1);
      run_to((5 + i) * L + 16);
      check($sformatf("tab%0d_p15", i), dout, tab[i].e15);
    end

    // Mid-ramp reset with a sample sitting in the buffer.
    run_to(10 * L + 5);
    check("prerst_ready", ready, 0);
    check("prerst_underrun", underrun, 0);
    #2;
    rst_n = 1'b0;
    feed_on = 1'b0; feed_acc = 1'b0; valid = 1'b0;
    src_q.delete();
    #1;
    check_reset_outputs("rst_mid");
    exp_q.delete();
    pulse_cnt = 0;
    cycle();
    cycle();
    rst_n = 1'b1;

    // Idle timebase: strobe spacing, flat zero output, underrun on 16th tick.
    push_seg(0, 0, L);
    prev_pc = 0;
    for (int k = 1; k <= 16; k++) begin
      run_to(k);
      if (k > 1) check($sformatf("idle_spacing%0d", k), last_pulse_cyc - prev_pc, 4);
      prev_pc = last_pulse_cyc;
      if (k == 15) check("idle_underrun_before", underrun, 0);
      if (k == 16) check("idle_underrun_set", underrun, 1);
    end
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check("underrun_clear", underrun, 0);

    // Backpressure: A fills the buffer, B waits for the wrap to drain it.
    push_seg(8'h00, 8'h00, L);
    push_seg(8'h00, 8'h20, L);
    push_seg(8'h20, 8'h30, L);
    push_seg(8'h30, 8'h40, 6);
    valid = 1'b1; din = 8'h20;
    cycle();
    check("bp_ready_after_a", ready, 0);
    din = 8'h30;
    guard = 0;
    while (ready == 1'b0 && guard < 200) begin
      cycle();
      guard++;
    end
    check("bp_ready_at_wrap_strobe", sd_en, 1);
    check("bp_ready_at_wrap_pulse", pulse_cnt, 32);
    cycle();
    valid = 1'b0;
    check("bp_b_buffered", ready, 0);

    // Bypass: buffer empty, sample presented only on the wrap cycle.
    run_to(63);
    check("byp_ready_before", ready, 1);
    cycle(); cycle(); cycle();
    valid = 1'b1; din = 8'h40;
    cycle();
    valid = 1'b0;
    check("byp_wrap_pulse", pulse_cnt, 64);
    check("byp_no_underrun", underrun, 0);
    check("byp_nxt_empty", ready, 1);

    // Freeze at p=5 for 20 clocks; buffer still accepts.
    run_to(69);
    check("frz_p4", dout, 8'h34);
    en = 1'b0;
    hold_val = dout;
    p0 = pulse_cnt;
    changes = 0;
    valid = 1'b1; din = 8'h50;
    for (int k = 0; k < 20; k++) begin
      cycle();
      valid = 1'b0;
      if (dout !== hold_val) changes++;
    end
    check("frz_no_pulse", pulse_cnt - p0, 0);
    check("frz_data_const", changes, 0);
    check("frz_accept", ready, 0);
    en = 1'b1;
    c0 = cyc_cnt;
    run_to(70);
    check("frz_resume_p5", dout, 8'h35);
    check("frz_resume_delay", last_pulse_cyc - c0, 4);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sdm_interp_feeder
`default_nettype wire
